// File: rtl/riscv_core_p.sv
// rtl/riscv_core_p.sv - shared RV32I encodings and multicycle controller enums
package riscv_core_p;

    typedef enum logic [6:0] {
        OPC_LOAD   = 7'b0000011,
        OPC_FENCE  = 7'b0001111,
        OPC_IMM    = 7'b0010011,
        OPC_AUIPC  = 7'b0010111,
        OPC_STORE  = 7'b0100011,
        OPC_OP     = 7'b0110011,
        OPC_LUI    = 7'b0110111,
        OPC_BRANCH = 7'b1100011,
        OPC_JALR   = 7'b1100111,
        OPC_JAL    = 7'b1101111,
        OPC_SYSTEM = 7'b1110011
    } OpCode;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } ALUOp;

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } RType;

    typedef union packed {
        logic [31:0] raw;
        RType        r;
    } Instruction;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WRITEBACK, S_TRAP
    } CtrlState;

    typedef enum logic [1:0] {PC_PLUS4 = 2'd0, PC_TARGET = 2'd1, PC_ALU = 2'd2} PcSel;
    typedef enum logic [1:0] {WB_ALU = 2'd0, WB_MEM = 2'd1, WB_PC4 = 2'd2} WbSel;
    typedef enum logic [1:0] {A_RS1 = 2'd0, A_PC = 2'd1, A_ZERO = 2'd2} AluSrcA;
    typedef enum logic [1:0] {B_RS2 = 2'd0, B_IMM = 2'd1, B_FOUR = 2'd2} AluSrcB;

    // SYSTEM is deliberately absent: the controller treats it as a trap source.
    function automatic logic is_exec_opcode(input logic [6:0] opc);
        case (opc)
            OPC_LOAD, OPC_FENCE, OPC_IMM, OPC_AUIPC, OPC_STORE,
            OPC_OP, OPC_LUI, OPC_BRANCH, OPC_JALR, OPC_JAL: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/riscv_multicycle_ctrl_if.sv
// rtl/riscv_multicycle_ctrl_if.sv - instruction/data memory request-acknowledge handshake
interface riscv_multicycle_ctrl_if;
    logic imem_req;
    logic imem_ack;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ack;

    modport master (output imem_req, dmem_req, dmem_we, input imem_ack, dmem_ack);
    modport slave  (input imem_req, dmem_req, dmem_we, output imem_ack, dmem_ack);
endinterface

// File: rtl/riscv_alu_decode.sv
// rtl/riscv_alu_decode.sv - combinational opcode/funct3/funct7[5] to ALU operation decode
module riscv_alu_decode
    import riscv_core_p::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_b5,
    output ALUOp       alu_op
);

    always_comb begin
        alu_op = ALU_ADD;
        case (opcode)
            OPC_OP, OPC_IMM: begin
                case (funct3)
                    // ADDI has no subtract form; bit 30 there is immediate data.
                    3'b000: alu_op = (opcode == OPC_OP && funct7_b5) ? ALU_SUB : ALU_ADD;
                    3'b001: alu_op = ALU_SLL;
                    3'b010: alu_op = ALU_SLT;
                    3'b011: alu_op = ALU_SLTU;
                    3'b100: alu_op = ALU_XOR;
                    3'b101: alu_op = funct7_b5 ? ALU_SRA : ALU_SRL;
                    3'b110: alu_op = ALU_OR;
                    3'b111: alu_op = ALU_AND;
                endcase
            end
            OPC_BRANCH: begin
                case (funct3[2:1])
                    2'b00:   alu_op = ALU_SUB;
                    2'b10:   alu_op = ALU_SLT;
                    2'b11:   alu_op = ALU_SLTU;
                    default: alu_op = ALU_ADD;
                endcase
            end
            default: alu_op = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/riscv_multicycle_ctrl.sv
// rtl/riscv_multicycle_ctrl.sv - RV32I multicycle control FSM; RISCV_INSTRET_EN adds a retired-instruction counter
module riscv_multicycle_ctrl
    import riscv_core_p::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [31:0]              instruction,
    input  logic                     branch_taken,
    riscv_multicycle_ctrl_if.master  mem,
    output logic                     ir_write,
    output logic                     pc_write,
    output logic                     reg_write,
    output logic [1:0]               pc_sel,
    output logic [3:0]               alu_op,
    output logic [1:0]               alu_src_a,
    output logic [1:0]               alu_src_b,
    output logic [1:0]               wb_sel,
    output logic                     fault
`ifdef RISCV_INSTRET_EN
    ,
    output logic [63:0]              instret
`endif
);

    localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT_CYCLES - 1);

    CtrlState   state, state_next;
    logic [7:0] wait_cnt;
    Instruction ir;
    logic [6:0] opc;
    ALUOp       dec_op;
    logic       unused_ir;

    assign ir        = instruction;
    assign opc       = ir.r.opcode;
    assign unused_ir = ^{ir.r.funct7[6], ir.r.funct7[4:0], ir.r.rs2, ir.r.rs1, ir.r.rd};

    riscv_alu_decode u_alu_decode (
        .opcode   (opc),
        .funct3   (ir.r.funct3),
        .funct7_b5(ir.r.funct7[5]),
        .alu_op   (dec_op)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
        end else begin
            state <= state_next;
            // Any state change re-arms the counter, so FETCH/MEM always start from zero.
            if (state_next != state)
                wait_cnt <= '0;
            else if (state == S_FETCH || state == S_MEM)
                wait_cnt <= wait_cnt + 8'd1;
        end
    end

    always_comb begin
        state_next   = state;
        mem.imem_req = 1'b0;
        mem.dmem_req = 1'b0;
        mem.dmem_we  = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        reg_write    = 1'b0;
        pc_sel       = PC_PLUS4;
        wb_sel       = WB_ALU;
        alu_op       = ALU_ADD;
        alu_src_a    = A_RS1;
        alu_src_b    = B_RS2;
        fault        = 1'b0;

        if (state == S_EXECUTE || state == S_MEM || state == S_WRITEBACK) begin
            alu_op = dec_op;
            case (opc)
                OPC_IMM, OPC_LOAD, OPC_STORE, OPC_JALR: alu_src_b = B_IMM;
                OPC_LUI:   begin alu_src_a = A_ZERO; alu_src_b = B_IMM;  end
                OPC_AUIPC: begin alu_src_a = A_PC;   alu_src_b = B_IMM;  end
                OPC_JAL:   begin alu_src_a = A_PC;   alu_src_b = B_FOUR; end
                default: ;
            endcase
        end

        case (state)
            S_IDLE: state_next = S_FETCH;
            S_FETCH: begin
                mem.imem_req = 1'b1;
                if (mem.imem_ack) begin
                    ir_write   = 1'b1;
                    state_next = S_DECODE;
                end else if (wait_cnt == WAIT_LIMIT) begin
                    state_next = S_TRAP;
                end
            end
            S_DECODE: state_next = is_exec_opcode(opc) ? S_EXECUTE : S_TRAP;
            S_EXECUTE: begin
                case (opc)
                    OPC_OP, OPC_IMM, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR:
                        state_next = S_WRITEBACK;
                    OPC_LOAD, OPC_STORE: state_next = S_MEM;
                    OPC_BRANCH: begin
                        pc_write   = 1'b1;
                        pc_sel     = branch_taken ? PC_TARGET : PC_PLUS4;
                        state_next = S_FETCH;
                    end
                    OPC_FENCE: begin
                        pc_write   = 1'b1;
                        state_next = S_FETCH;
                    end
                    default: state_next = S_TRAP;
                endcase
            end
            S_MEM: begin
                mem.dmem_req = 1'b1;
                mem.dmem_we  = (opc == OPC_STORE);
                if (mem.dmem_ack) begin
                    if (opc == OPC_STORE) begin
                        pc_write   = 1'b1;
                        state_next = S_FETCH;
                    end else begin
                        state_next = S_WRITEBACK;
                    end
                end else if (wait_cnt == WAIT_LIMIT) begin
                    state_next = S_TRAP;
                end
            end
            S_WRITEBACK: begin
                reg_write  = 1'b1;
                pc_write   = 1'b1;
                state_next = S_FETCH;
                case (opc)
                    OPC_LOAD: wb_sel = WB_MEM;
                    OPC_JAL:  begin wb_sel = WB_PC4; pc_sel = PC_TARGET; end
                    OPC_JALR: begin wb_sel = WB_PC4; pc_sel = PC_ALU;    end
                    default: ;
                endcase
            end
            S_TRAP:  fault = 1'b1;
            default: state_next = S_TRAP;
        endcase
    end

`ifdef RISCV_INSTRET_EN
    always_ff @(posedge clk) begin
        if (!rst_n)
            instret <= '0;
        else if (pc_write && state != S_TRAP)
            instret <= instret + 64'd1;
    end
`endif

endmodule
